// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and defaults for the stopwatch core.
//   state_e      : top-level FSM states (IDLE, RUN, STOP)
//   *_DEFAULT    : default timing constants for a 100 MHz system clock
//   COUNT_W      : width of the elapsed-count output
//   ctrWidth()   : width of a counter that has to reach n-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int TICK_DIV_DEFAULT        = 1_000_000;
    localparam int MAX_COUNT_DEFAULT       = 10000;
    localparam int COUNT_W                 = 14;

    function automatic int ctrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes a raw push button, debounces it and emits a single-cycle pulse
// for every accepted press (0->1). Releases never pulse.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw, asynchronous, active-high button
//   press_o : one-cycle press pulse (registered)
// -----------------------------------------------------------------------------
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int            CW       = ctrWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [1:0]    warm_q, warm_d;
    logic          armed_q, armed_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // The synchronizer resets to 0 even if the button is physically held, so
    // its first two samples after reset are meaningless. warm_q marks when the
    // chain has filled. Until then the debouncer is frozen. After that the
    // debouncer stays disarmed until it has seen the button released for a
    // full debounce window, so a press held through reset never pulses.
    always_comb begin
        warm_d   = {warm_q[0], 1'b1};
        armed_d  = armed_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (warm_q[1]) begin
            if (!armed_q) begin
                if (sync2_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    armed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Two-flop synchronizer plus all debounce state, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            warm_q   <= 2'b00;
            armed_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            warm_q   <= warm_d;
            armed_q  <= armed_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
// Run/stop/clear stopwatch counting in TICK_DIV clock units.
// Ports:
//   clk100Mhz : system clock, all logic on rising edge
//   rst_n     : asynchronous active-low reset
//   btnRun    : raw run/stop button (active high)
//   btnClear  : raw clear button (active high)
//   segData   : elapsed count, wraps at MAX_COUNT (registered)
//   idle      : high while in IDLE (registered)
//   running   : high while in RUN (registered)
// -----------------------------------------------------------------------------
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int TICK_DIV        = TICK_DIV_DEFAULT,
    parameter int MAX_COUNT       = MAX_COUNT_DEFAULT
) (
    input  logic                clk100Mhz,
    input  logic                rst_n,
    input  logic                btnRun,
    input  logic                btnClear,
    output logic [COUNT_W-1:0]  segData,
    output logic                idle,
    output logic                running
);

    localparam int                 PW         = ctrWidth(TICK_DIV);
    localparam logic [PW-1:0]      PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(MAX_COUNT - 1);

    logic               runPress;
    logic               clearPress;
    state_e             state_q, state_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               idle_q, running_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_runBtn (
        .clk_i   (clk100Mhz),
        .rst_ni  (rst_n),
        .btn_i   (btnRun),
        .press_o (runPress)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clearBtn (
        .clk_i   (clk100Mhz),
        .rst_ni  (rst_n),
        .btn_i   (btnClear),
        .press_o (clearPress)
    );

    // Next-state, prescaler and count. The prescaler advances in every cycle
    // spent in RUN, including the one in which a stop press arrives, and is
    // left untouched in STOP so a paused partial interval resumes intact.
    // In STOP a clear press beats a simultaneous run press.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (runPress) state_d = RUN;
            end
            RUN: begin
                if (runPress) state_d = STOP;
                if (pre_q == PRE_LAST) begin
                    pre_d   = '0;
                    count_d = (count_q == COUNT_LAST) ? '0 : count_q + 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            STOP: begin
                if (clearPress) begin
                    state_d = IDLE;
                    pre_d   = '0;
                    count_d = '0;
                end else if (runPress) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and the registered status flags. idle/running are
    // decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            count_q   <= '0;
            idle_q    <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            count_q   <= count_d;
            idle_q    <= (state_d == IDLE);
            running_q <= (state_d == RUN);
        end
    end

    assign segData = count_q;
    assign idle    = idle_q;
    assign running = running_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_core
// Self-checking bench for stopwatch_core with small timing parameters
// (DEBOUNCE_CYCLES=4, TICK_DIV=5, MAX_COUNT=10). Expectations are queued when
// stimulus is applied and popped when the corresponding output is sampled.
// -----------------------------------------------------------------------------
module tb_stopwatch_core;

    localparam int DEB  = 4;
    localparam int TICK = 5;
    localparam int MAXC = 10;

    localparam int SEL_RUN_HI  = 0;
    localparam int SEL_RUN_LO  = 1;
    localparam int SEL_IDLE_HI = 2;

    logic        clk100Mhz = 1'b0;
    logic        rst_n;
    logic        btnRun;
    logic        btnClear;
    logic [13:0] segData;
    logic        idle;
    logic        running;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        string tag;
        int    value;
    } expect_t;

    expect_t expQ[$];

    stopwatch_core #(
        .DEBOUNCE_CYCLES (DEB),
        .TICK_DIV        (TICK),
        .MAX_COUNT       (MAXC)
    ) dut (
        .clk100Mhz (clk100Mhz),
        .rst_n     (rst_n),
        .btnRun    (btnRun),
        .btnClear  (btnClear),
        .segData   (segData),
        .idle      (idle),
        .running   (running)
    );

    // 100 MHz clock; outputs are sampled and inputs driven on the falling edge.
    always #5 clk100Mhz = ~clk100Mhz;

    // Hard stop in case something stalls outside the bounded waits.
    initial begin
        #100us;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
        assertCount++;
        if (observed !== 32'(expected)) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input int value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic popCheck(input logic [31:0] observed, input string note);
        expect_t e;
        if (expQ.size() == 0) begin
            checkOutput({"scoreboardUnderflow", note}, 32'(expQ.size()), 1);
            return;
        end
        e = expQ.pop_front();
        checkOutput({e.tag, note}, observed, e.value);
    endtask

    // Queue the expected outputs, let the given number of cycles pass, then
    // compare them against what the DUT shows.
    task automatic expectAfter(input int cycles, input string tag,
                               input int segExp, input int idleExp, input int runExp);
        pushExpect({tag, ".segData"}, segExp);
        pushExpect({tag, ".idle"}, idleExp);
        pushExpect({tag, ".running"}, runExp);
        repeat (cycles) @(negedge clk100Mhz);
        popCheck(32'(segData), "");
        popCheck(32'(idle), "");
        popCheck(32'(running), "");
    endtask

    function automatic logic selHit(input int sel);
        case (sel)
            SEL_RUN_HI:  return running === 1'b1;
            SEL_RUN_LO:  return running === 1'b0;
            default:     return idle === 1'b1;
        endcase
    endfunction

    // Press the chosen buttons at a falling edge and wait for the selected
    // output change. The visible change trails the press by the synchronizer,
    // the debounce window, the pulse register and the state register: nominal
    // 7 falling edges, with one cycle of slack either way. Buttons are
    // released after 6 edges unless the press is meant to be held.
    task automatic applyStimulus(input logic pressRun, input logic pressClear, input int sel,
                                 input logic releaseAt6, input string tag);
        int lat;
        lat = 0;
        pushExpect(tag, 1);
        if (pressRun)   btnRun   = 1'b1;
        if (pressClear) btnClear = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk100Mhz);
            if (releaseAt6 && i == 6) begin
                btnRun   = 1'b0;
                btnClear = 1'b0;
            end
            if (lat == 0 && selHit(sel)) lat = i;
            if (lat != 0 && i >= 6) break;
        end
        popCheck(32'(lat >= 6 && lat <= 8), $sformatf(" (latency %0d)", lat));
    endtask

    task automatic holdButtons(input logic pressRun, input logic pressClear, input int hold);
        if (pressRun)   btnRun   = 1'b1;
        if (pressClear) btnClear = 1'b1;
        repeat (hold) @(negedge clk100Mhz);
        btnRun   = 1'b0;
        btnClear = 1'b0;
    endtask

    // Main sequence. Counts below are falling edges since the named event;
    // each edge spent in RUN is one prescaler step, five steps per count.
    initial begin
        rst_n    = 1'b0;
        btnRun   = 1'b0;
        btnClear = 1'b0;
        repeat (2) @(negedge clk100Mhz);
        expectAfter(0, "inReset", 0, 1, 0);
        rst_n = 1'b1;
        expectAfter(10, "afterReset", 0, 1, 0);

        // Start, first ticks and wrap 9 -> 0 at the 50th RUN cycle.
        applyStimulus(1'b1, 1'b0, SEL_RUN_HI, 1'b1, "startLatency");
        expectAfter(0, "started", 0, 0, 1);
        expectAfter(4, "beforeFirstTick", 0, 0, 1);
        expectAfter(1, "firstTick", 1, 0, 1);
        expectAfter(5, "secondTick", 2, 0, 1);
        expectAfter(39, "beforeWrap", 9, 0, 1);
        expectAfter(1, "wrapToZero", 0, 0, 1);

        // Clear while running is ignored; counting continues (70 steps).
        holdButtons(1'b0, 1'b1, 6);
        expectAfter(14, "clearIgnoredInRun", 4, 0, 1);

        // Stop after 77 steps: count 5 with 2 steps of partial interval.
        applyStimulus(1'b1, 1'b0, SEL_RUN_LO, 1'b1, "stopLatency");
        expectAfter(0, "stopped", 5, 0, 0);
        expectAfter(50, "heldInStop", 5, 0, 0);

        // Resume: the saved partial interval means the next tick comes after 3.
        applyStimulus(1'b1, 1'b0, SEL_RUN_HI, 1'b1, "resumeLatency");
        expectAfter(2, "resumePartial", 5, 0, 1);
        expectAfter(1, "resumeTick", 6, 0, 1);
        expectAfter(2, "beforeSecondStop", 6, 0, 1);
        applyStimulus(1'b1, 1'b0, SEL_RUN_LO, 1'b1, "secondStopLatency");
        expectAfter(0, "secondStop", 7, 0, 0);

        // Clear in STOP returns to IDLE with the count zeroed.
        applyStimulus(1'b0, 1'b1, SEL_IDLE_HI, 1'b1, "clearLatency");
        expectAfter(0, "clearedInStop", 0, 1, 0);
        expectAfter(6, "idleAfterClear", 0, 1, 0);

        // Both buttons in IDLE: run acts. Prescaler restarts from zero.
        applyStimulus(1'b1, 1'b1, SEL_RUN_HI, 1'b1, "bothInIdleLatency");
        expectAfter(0, "runWinsInIdle", 0, 0, 1);
        expectAfter(4, "prescalerClearedA", 0, 0, 1);
        expectAfter(1, "prescalerClearedB", 1, 0, 1);
        applyStimulus(1'b1, 1'b0, SEL_RUN_LO, 1'b1, "thirdStopLatency");
        expectAfter(0, "thirdStop", 2, 0, 0);
        expectAfter(6, "waitInStop", 2, 0, 0);

        // Both buttons in STOP: clear wins.
        applyStimulus(1'b1, 1'b1, SEL_IDLE_HI, 1'b1, "bothInStopLatency");
        expectAfter(0, "clearWinsInStop", 0, 1, 0);

        // Asynchronous reset mid-count with the run button held across it.
        expectAfter(10, "idleBeforeRestart", 0, 1, 0);
        applyStimulus(1'b1, 1'b0, SEL_RUN_HI, 1'b1, "restartLatency");
        expectAfter(30, "sixBeforeReset", 6, 0, 1);
        #2;
        rst_n  = 1'b0;
        btnRun = 1'b1;
        #1;
        expectAfter(0, "asyncReset", 0, 1, 0);
        repeat (2) @(negedge clk100Mhz);
        rst_n = 1'b1;
        expectAfter(40, "heldThroughReset", 0, 1, 0);
        btnRun = 1'b0;
        expectAfter(10, "releasedAfterReset", 0, 1, 0);
        applyStimulus(1'b1, 1'b0, SEL_RUN_HI, 1'b1, "pressAfterRelease");
        expectAfter(0, "runAfterRelease", 0, 0, 1);

        // Bouncing button: toggles every 2 cycles, then held high.
        @(negedge clk100Mhz);
        rst_n = 1'b0;
        repeat (2) @(negedge clk100Mhz);
        rst_n = 1'b1;
        repeat (10) @(negedge clk100Mhz);
        for (int i = 0; i < 10; i++) begin
            btnRun = (i % 2 == 0);
            repeat (2) @(negedge clk100Mhz);
        end
        expectAfter(0, "noPulseDuringBounce", 0, 1, 0);
        applyStimulus(1'b1, 1'b0, SEL_RUN_HI, 1'b0, "bounceLatency");
        expectAfter(40, "singlePulseWhileHeld", 8, 0, 1);
        btnRun = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
